// File: rtl/sd_word_packer_if.sv
// sd_word_packer_if
//   Bundles the two srdy/drdy channels of sd_word_packer.
//   Consumer side (narrow words in):
//     c_srdy  word valid            c_drdy  packer ready
//     c_data  width-bit word        c_eop   last word of packet
//   Producer side (packed words out):
//     p_srdy  packed word valid     p_drdy  downstream ready
//     p_data  ratio*width bits      p_cnt   valid lanes, 1..ratio
//     p_eop   packed word closes a packet
//   slave  : the packer's view.
//   master : the view of the logic that feeds and drains the packer.
interface sd_word_packer_if #(
  parameter int width = 8,
  parameter int ratio = 4,
  parameter int usz   = $clog2(ratio + 1)
);
  logic                     c_srdy;
  logic                     c_drdy;
  logic [width-1:0]         c_data;
  logic                     c_eop;
  logic                     p_srdy;
  logic                     p_drdy;
  logic [ratio*width-1:0]   p_data;
  logic [usz-1:0]           p_cnt;
  logic                     p_eop;

  modport slave (
    input  c_srdy, c_data, c_eop, p_drdy,
    output c_drdy, p_srdy, p_data, p_cnt, p_eop
  );

  modport master (
    output c_srdy, c_data, c_eop, p_drdy,
    input  c_drdy, p_srdy, p_data, p_cnt, p_eop
  );
endinterface

// File: rtl/sd_word_packer.sv
// sd_word_packer
//   Gathers up to `ratio` consecutive width-bit words into one packed word.
//   Word k of a group lands in lane k (bits [k*width +: width]); unused lanes
//   read 0. c_eop closes a group early and p_cnt reports how many lanes hold
//   data. An accumulator plus an output register keep one word per cycle
//   flowing with no bubbles while the downstream side is ready.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; discards any partial/held word
//   bus      sd_word_packer_if.slave (c_* consumer side, p_* producer side)
module sd_word_packer #(
  parameter int width = 8,
  parameter int ratio = 4,
  parameter int usz   = $clog2(ratio + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  sd_word_packer_if.slave   bus
);

  localparam int CNT_W = $clog2(ratio);

  // Accumulator modes: FILL takes words, HELD parks a closed word until the
  // output register can take it.
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [0:0]             state_p0;
  logic [ratio*width-1:0] acc_data_p0;
  logic [CNT_W-1:0]       acc_cnt_p0;
  logic                   acc_eop_p0;

  logic                   vld_p1;
  logic [ratio*width-1:0] data_p1;
  logic [usz-1:0]         cnt_p1;
  logic                   eop_p1;

  logic                   acc_full;
  logic                   out_free;
  logic                   c_xfer;
  logic                   last_lane;
  logic                   close_word;
  logic                   bypass;
  logic                   move;
  logic [ratio*width-1:0] ins_data;
  logic [usz-1:0]         lanes_used;

  assign acc_full   = (state_p0 == HELD);
  // The output register can accept a word when empty or being drained now.
  assign out_free   = !vld_p1 || bus.p_drdy;
  assign bus.c_drdy = reset_n && !acc_full;
  assign c_xfer     = bus.c_srdy && bus.c_drdy;
  assign last_lane  = (acc_cnt_p0 == CNT_W'(ratio - 1));
  assign close_word = c_xfer && (last_lane || bus.c_eop);
  assign bypass     = close_word && out_free;
  assign move       = acc_full && out_free;
  // acc_cnt is frozen in HELD, so this also gives the held word's lane count.
  assign lanes_used = usz'(acc_cnt_p0) + usz'(1);

  // Accumulator contents with the incoming word dropped into lane acc_cnt.
  always_comb begin
    ins_data = acc_data_p0;
    for (int l = 0; l < ratio; l++) begin
      if (acc_cnt_p0 == CNT_W'(l)) begin
        ins_data[l*width +: width] = bus.c_data;
      end
    end
  end

  // ---- Stage p0: accumulator ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0    <= FILL;
      acc_data_p0 <= '0;
      acc_cnt_p0  <= '0;
      acc_eop_p0  <= 1'b0;
    end else begin
      case (state_p0)
        FILL: begin
          if (c_xfer) begin
            if (close_word) begin
              if (out_free) begin
                // Closed word goes straight to the output register.
                acc_data_p0 <= '0;
                acc_cnt_p0  <= '0;
                acc_eop_p0  <= 1'b0;
              end else begin
                state_p0    <= HELD;
                acc_data_p0 <= ins_data;
                acc_eop_p0  <= bus.c_eop;
              end
            end else begin
              acc_data_p0 <= ins_data;
              acc_cnt_p0  <= acc_cnt_p0 + CNT_W'(1);
            end
          end
        end
        HELD: begin
          if (out_free) begin
            state_p0    <= FILL;
            acc_data_p0 <= '0;
            acc_cnt_p0  <= '0;
            acc_eop_p0  <= 1'b0;
          end
        end
        default: state_p0 <= FILL;
      endcase
    end
  end

  // ---- Stage p1: output register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      cnt_p1  <= '0;
      eop_p1  <= 1'b0;
    end else if (bypass) begin
      vld_p1  <= 1'b1;
      data_p1 <= ins_data;
      cnt_p1  <= lanes_used;
      eop_p1  <= bus.c_eop;
    end else if (move) begin
      vld_p1  <= 1'b1;
      data_p1 <= acc_data_p0;
      cnt_p1  <= lanes_used;
      eop_p1  <= acc_eop_p0;
    end else if (bus.p_drdy) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.p_srdy = vld_p1;
  assign bus.p_data = data_p1;
  assign bus.p_cnt  = cnt_p1;
  assign bus.p_eop  = eop_p1;

endmodule

// File: tb/tb_sd_word_packer.sv
module tb_sd_word_packer;
  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int USZ   = $clog2(RATIO + 1);

  typedef struct packed {
    logic [RATIO*WIDTH-1:0] d;
    logic [USZ-1:0]         c;
    logic                   e;
  } pkt_t;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  pkt_t       want_q[$];
  logic [7:0] grp[$];

  sd_word_packer_if #(.width(WIDTH), .ratio(RATIO), .usz(USZ)) bus ();

  sd_word_packer #(.width(WIDTH), .ratio(RATIO), .usz(USZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Reference model: input words are grouped as the rules state (close at
  // RATIO words or on eop); each group becomes one expected packed word.
  always @(negedge clk) begin
    if (!reset_n) begin
      want_q.delete();
      grp.delete();
    end else begin
      if (bus.p_srdy && bus.p_drdy) begin
        if (want_q.size() == 0) begin
          check("sb_unexpected_out", 64'(want_q.size()), 64'd1);
        end else begin
          pkt_t w;
          w = want_q.pop_front();
          check("sb_data", 64'(bus.p_data), 64'(w.d));
          check("sb_cnt",  64'(bus.p_cnt),  64'(w.c));
          check("sb_eop",  64'(bus.p_eop),  64'(w.e));
        end
      end
      if (bus.c_srdy && bus.c_drdy) begin
        grp.push_back(bus.c_data);
        if (grp.size() == RATIO || bus.c_eop) begin
          pkt_t w;
          w.d = '0;
          for (int k = 0; k < grp.size(); k++) w.d[k*WIDTH +: WIDTH] = grp[k];
          w.c = USZ'(grp.size());
          w.e = bus.c_eop;
          want_q.push_back(w);
          grp.delete();
        end
      end
    end
  end

  task automatic put(input logic [7:0] d, input logic e);
    int n;
    n = 0;
    bus.c_srdy = 1'b1;
    bus.c_data = d;
    bus.c_eop  = e;
    @(negedge clk);
    while (!bus.c_drdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("put_accept", 64'(bus.c_drdy), 64'd1);
    @(posedge clk);
    #1;
    bus.c_srdy = 1'b0;
    bus.c_eop  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.c_srdy = 1'b0;
    bus.p_drdy = 1'b1;
    @(negedge clk);
    while ((want_q.size() != 0 || bus.p_srdy) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(tag, 64'(want_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int words;
    int cyc;
    logic [7:0] sp;
    logic [7:0] dp;
    logic [7:0] pat_s[3];
    logic [7:0] pat_d[3];
    logic took;

    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.c_srdy  = 1'b0;
    bus.c_data  = '0;
    bus.c_eop   = 1'b0;
    bus.p_drdy  = 1'b0;
    pat_s[0] = 8'h5A; pat_d[0] = 8'hA5;
    pat_s[1] = 8'hFD; pat_d[1] = 8'h03;
    pat_s[2] = 8'h11; pat_d[2] = 8'hEE;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p_srdy", 64'(bus.p_srdy), 64'd0);
    check("rst_c_drdy", 64'(bus.c_drdy), 64'd0);
    check("rst_p_data", 64'(bus.p_data), 64'd0);
    check("rst_p_cnt",  64'(bus.p_cnt),  64'd0);
    check("rst_p_eop",  64'(bus.p_eop),  64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_c_drdy", 64'(bus.c_drdy), 64'd1);
    @(posedge clk);
    #1;

    // Streaming 0x01..0x08
    bus.p_drdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.c_srdy = 1'b1;
      bus.c_data = 8'(i + 1);
      bus.c_eop  = 1'b0;
      @(negedge clk);
      check("stream_c_drdy", 64'(bus.c_drdy), 64'd1);
      if (i == 3) check("stream_lat_early", 64'(bus.p_srdy), 64'd0);
      if (i == 4) begin
        check("stream_lat",   64'(bus.p_srdy), 64'd1);
        check("stream_w0",    64'(bus.p_data), 64'h04030201);
        check("stream_cnt0",  64'(bus.p_cnt),  64'd4);
        check("stream_eop0",  64'(bus.p_eop),  64'd0);
      end
      @(posedge clk);
      #1;
    end
    bus.c_srdy = 1'b0;
    @(negedge clk);
    check("stream_w1_vld", 64'(bus.p_srdy), 64'd1);
    check("stream_w1",     64'(bus.p_data), 64'h08070605);
    @(posedge clk);
    #1;

    // Partial word closed by eop, then a fresh group
    put(8'hA1, 1'b0);
    put(8'hA2, 1'b0);
    put(8'hA3, 1'b1);
    @(negedge clk);
    check("part_data", 64'(bus.p_data), 64'h00A3A2A1);
    check("part_cnt",  64'(bus.p_cnt),  64'd3);
    check("part_eop",  64'(bus.p_eop),  64'd1);
    @(posedge clk);
    #1;
    put(8'hB1, 1'b0);
    put(8'hB2, 1'b0);
    put(8'hB3, 1'b0);
    put(8'hB4, 1'b0);
    @(negedge clk);
    check("part_next", 64'(bus.p_data), 64'hB4B3B2B1);
    @(posedge clk);
    #1;

    // Single-word packet
    put(8'h5C, 1'b1);
    @(negedge clk);
    check("single_data", 64'(bus.p_data), 64'h0000005C);
    check("single_cnt",  64'(bus.p_cnt),  64'd1);
    check("single_eop",  64'(bus.p_eop),  64'd1);
    drain("single_drain");

    // Backpressure: 12 words against a stalled output
    bus.p_drdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      bus.c_srdy = (acc < 12);
      bus.c_data = 8'(acc + 1);
      @(negedge clk);
      if (acc == 8) check("bp_c_drdy_low", 64'(bus.c_drdy), 64'd0);
      if (acc >= 4) check("bp_hold_data", 64'(bus.p_data), 64'h04030201);
      if (bus.c_srdy && bus.c_drdy) acc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepts_stalled", 64'(acc), 64'd8);
    bus.p_drdy = 1'b1;
    for (int c = 0; c < 40 && acc < 12; c++) begin
      bus.c_srdy = 1'b1;
      bus.c_data = 8'(acc + 1);
      @(negedge clk);
      if (bus.c_srdy && bus.c_drdy) acc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepts_total", 64'(acc), 64'd12);
    drain("bp_drain");

    // Random handshake patterns with random eop
    words = 0;
    cyc   = 0;
    bus.c_data = 8'($urandom);
    bus.c_eop  = ($urandom_range(5) == 0);
    sp = 8'h00;
    dp = 8'h00;
    while (words < 2000 && cyc < 30000) begin
      if (cyc % 64 == 0) begin
        if (cyc / 64 < 3) begin
          sp = pat_s[cyc / 64];
          dp = pat_d[cyc / 64];
        end else begin
          sp = 8'($urandom);
          dp = 8'($urandom);
          if (sp == 8'h00) sp = 8'h01;
          if (dp == 8'h00) dp = 8'h80;
        end
      end
      bus.c_srdy = sp[cyc % 8];
      bus.p_drdy = dp[cyc % 8];
      @(negedge clk);
      took = bus.c_srdy && bus.c_drdy;
      if (took) words++;
      @(posedge clk);
      #1;
      if (took) begin
        bus.c_data = 8'($urandom);
        bus.c_eop  = ($urandom_range(5) == 0);
      end
      cyc++;
    end
    bus.c_srdy = 1'b0;
    check("rand_words", 64'(words), 64'd2000);
    bus.p_drdy = 1'b1;
    put(8'hEE, 1'b1);
    drain("rand_drain");

    // Mid-operation reset with output full and 2 words accumulated
    bus.p_drdy = 1'b0;
    put(8'h11, 1'b0);
    put(8'h22, 1'b0);
    put(8'h33, 1'b0);
    put(8'h44, 1'b0);
    put(8'h55, 1'b0);
    put(8'h66, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_p_srdy", 64'(bus.p_srdy), 64'd0);
    check("mrst_p_data", 64'(bus.p_data), 64'd0);
    check("mrst_p_cnt",  64'(bus.p_cnt),  64'd0);
    check("mrst_c_drdy", 64'(bus.c_drdy), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.p_drdy = 1'b1;
    put(8'hC1, 1'b0);
    put(8'hC2, 1'b0);
    put(8'hC3, 1'b0);
    put(8'hC4, 1'b0);
    @(negedge clk);
    check("mrst_post_data", 64'(bus.p_data), 64'hC4C3C2C1);
    check("mrst_post_cnt",  64'(bus.p_cnt),  64'd4);
    @(posedge clk);
    #1;
    drain("final_drain");
    check("final_grp_empty", 64'(grp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sd_word_packer.md
Name: sd_word_packer

Overview:
- Width-widening packer that sits directly downstream of sd_demux2.
- Gathers `ratio` consecutive `width`-bit srdy/drdy words into one packed `ratio*width`-bit word.
- An end-of-packet flag on the input closes a partial word early; the output reports how many lanes are valid.
- Double-buffered (accumulator plus output register), so it sustains one input word per cycle with no bubbles.

Parameters:
- width, 8, bits per input word / per output lane.
- ratio, 4, input words per packed output word; legal range 2 or more.
- usz, $clog2(ratio+1), width of the lane-count output.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- c_srdy  input  1  consumer-side word valid.
- c_drdy  output  1  consumer-side ready.
- c_data  input  width  input word.
- c_eop  input  1  word is the last of its packet; qualified by c_srdy.
- p_srdy  output  1  packed word valid.
- p_drdy  input  1  downstream ready.
- p_data  output  ratio*width  packed word.
- p_cnt  output  usz  number of valid lanes, 1..ratio.
- p_eop  output  1  packed word closes a packet.

Behaviour:
- Transfers:
  - A consumer-side transfer occurs when c_srdy and c_drdy are both 1 on a clk edge.
  - A producer-side transfer occurs when p_srdy and p_drdy are both 1 on a clk edge.
- Lane order: the first word of a group goes to lane 0, bits [width-1:0]. Word k goes to bits [k*width +: width]. Lanes beyond p_cnt are driven 0.
- Accumulator state:
  - acc_data (ratio*width bits), acc_cnt (0..ratio-1), acc_eop, acc_full.
  - acc_full = accumulator holds a closed word waiting for the output register.
- State machine:
  - FILL (acc_full=0):
    - c_drdy=1.
    - On accept, write c_data into lane acc_cnt.
    - The word is closed when acc_cnt==ratio-1 or c_eop=1.
  - HELD (acc_full=1):
    - c_drdy=0.
    - Moves to the output register when the output register is free, i.e. p_srdy==0 or p_drdy==1 on the same edge; then returns to FILL with acc_cnt=0.
- Closing a word while in FILL:
  - If the output register is free on that edge (p_srdy==0, or p_srdy&p_drdy): the word bypasses directly to the output register and acc_cnt returns to 0. Latency is 1 cycle from the final accepted word to p_srdy=1.
  - Otherwise: go to HELD, holding the closed word, acc_cnt+1 valid lanes and eop.
- Output register:
  - Loads p_data, p_cnt (lanes in the closed word) and p_eop.
  - Sets p_srdy=1.
  - p_srdy clears after a transfer unless a new word loads on the same edge.
  - While p_srdy=1 and p_drdy=0, p_data, p_cnt and p_eop are held stable.
- Simultaneous events:
  - An output transfer, HELD→output move and new input accept can all happen on one edge.
  - Sustained c_srdy=1 with p_drdy=1 yields c_drdy=1 every cycle.
- c_eop on a non-final lane closes the word with p_cnt=lane+1 and p_eop=1. The next word starts at lane 0.
- c_eop on lane ratio-1 gives p_cnt=ratio, p_eop=1.
- acc_cnt never reaches ratio; there is no wrap beyond ratio-1.
- Reset:
  - reset_n=0 asynchronously clears acc_data, acc_cnt, acc_eop, acc_full, p_srdy, p_data, p_cnt and p_eop to 0.
  - c_drdy is forced to 0 while reset_n=0, and is 1 on the first cycle after release.
  - A partially filled or held word is discarded on reset; there is no partial flush.

Test Plan:
All scenarios use width=8, ratio=4.
- Streaming: stream 0x01..0x08, no eop, p_drdy=1 → p_data 0x04030201 then 0x08070605, p_cnt=4, p_eop=0. p_srdy rises 1 cycle after the 4th accept. c_drdy stays 1 throughout.
- Partial word: send 0xA1, 0xA2, 0xA3 with c_eop on 0xA3, then 0xB1.. → first output 0x00A3A2A1, p_cnt=3, p_eop=1. The next group starts with 0xB1 in lane 0.
- Single-word packet: one word 0x5C with c_eop=1 → p_data 0x0000005C, p_cnt=1, p_eop=1.
- Backpressure:
  - p_drdy=0, send 12 words → c_drdy drops to 0 after the 8th accept (output and accumulator both full). p_data stays at 0x04030201 while stalled.
  - Then raise p_drdy=1 → three words emerge in order, with no loss or duplication.
- Random handshake:
  - Stimulus: srdy patterns 8'h5A/8'hFD/8'h11 against drdy patterns 8'hA5/8'h03/8'hEE, then random patterns, with random eop at about 1/6 probability, over 2000 words.
  - Required: scoreboard matches every lane, p_cnt and p_eop; zero mismatches.
- Mid-operation reset: drop reset_n with 2 words in the accumulator and the output register full → p_srdy, p_data and p_cnt read 0 immediately, before the next clk edge. After release, the first packed word contains only post-reset data in lanes 0..3.
